// File: rtl/fp_unit_arbiter.sv
// Two-requester sequencer for the shared combinational FP add/multiply unit.
// Define FP_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module fp_unit_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data,
    output logic        fu_op,
    output logic [31:0] fu_a,
    output logic [31:0] fu_b,
    input  logic [31:0] fu_result,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        id_q, id_d;
    logic        fu_op_q, fu_op_d;
    logic [31:0] fu_a_q, fu_a_d;
    logic [31:0] fu_b_q, fu_b_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_id_q, resp_id_d;
    logic        pick1;
    logic        grant0, grant1;
    logic        hs0, hs1;

`ifdef FP_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        pick1 = req1_valid && (!req0_valid || !last_grant_q);
    end
`else
    always_comb begin
        pick1 = req1_valid && !req0_valid;
    end
`endif

    always_comb begin
        grant0     = req0_valid && !pick1;
        grant1     = pick1;
        req0_ready = (state_q == ST_IDLE) && !reset && grant0;
        req1_ready = (state_q == ST_IDLE) && !reset && grant1;
        hs0        = req0_valid && req0_ready;
        hs1        = req1_valid && req1_ready;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        fu_op_d     = fu_op_q;
        fu_a_d      = fu_a_q;
        fu_b_d      = fu_b_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
`ifdef FP_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (hs0 || hs1) begin
                    fu_op_d = hs1 ? req1_op : req0_op;
                    fu_a_d  = hs1 ? req1_a  : req0_a;
                    fu_b_d  = hs1 ? req1_b  : req0_b;
                    id_d    = hs1;
                    cnt_d   = CNT_INIT;
                    state_d = ST_EXEC;
`ifdef FP_ARB_ROUND_ROBIN_EN
                    last_grant_d = hs1;
`endif
                end
            end
            ST_EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    resp_data_d = fu_result;
                    resp_id_d   = id_q;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            id_q        <= 1'b0;
            fu_op_q     <= 1'b0;
            fu_a_q      <= 32'd0;
            fu_b_q      <= 32'd0;
            resp_data_q <= 32'd0;
            resp_id_q   <= 1'b0;
`ifdef FP_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            fu_op_q     <= fu_op_d;
            fu_a_q      <= fu_a_d;
            fu_b_q      <= fu_b_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
`ifdef FP_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign fu_op      = fu_op_q;
    assign fu_a       = fu_a_q;
    assign fu_b       = fu_b_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign resp_valid = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed bench for fp_unit_arbiter with a lookup-table stand-in for the FP unit.
module tb_fp_unit_arbiter;

    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_op;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_op;
    logic [31:0] req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_data;
    logic        fu_op;
    logic [31:0] fu_a, fu_b, fu_result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Known IEEE-754 results for the vectors used below.
    function automatic logic [31:0] fp_model(input logic op, input logic [31:0] a, input logic [31:0] b);
        if (op && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        if (!op && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
        if (!op && a == 32'h40000000 && b == 32'h40400000) return 32'h40A00000;
        if (op && a == 32'h3F800000 && b == 32'h40400000) return 32'h40400000;
        if (op && a == 32'h7F800000 && b == 32'h00000000) return 32'h7FC00000;
        return 32'hDEADBEEF ^ a ^ b;
    endfunction

    assign fu_result = fp_model(fu_op, fu_a, fu_b);

    fp_unit_arbiter #(.LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data),
        .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b), .fu_result(fu_result),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nb;
        int  n;
        bit  got;
        bit  winner;
        bit  exp_w;
        logic [31:0] cap_data;
        logic        cap_id;

        reset = 1'b1; resp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'h0; req0_b = 32'h0;
        req1_valid = 1'b0; req1_op = 1'b0; req1_a = 32'h0; req1_b = 32'h0;

        // Reset state
        step(); #1;
        check("rst_rdy0", 32'(req0_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rv", 32'(resp_valid), 32'd0);
        check("rst_fua", fu_a, 32'd0);
        check("rst_rdata", resp_data, 32'd0);
        check("rst_rid", 32'(resp_id), 32'd0);
        step();
        reset = 1'b0; req0_valid = 1'b0;

        // Single multiply from requester 0
        step();
        req0_valid = 1'b1; req0_op = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40400000;
        #1;
        check("mul_rdy0", 32'(req0_ready), 32'd1);
        check("mul_rdy1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        #1;
        check("mul_fuop", 32'(fu_op), 32'd1);
        check("mul_fua", fu_a, 32'h40000000);
        check("mul_fub", fu_b, 32'h40400000);
        check("mul_busy", 32'(busy), 32'd1);
        check("mul_rv_t1", 32'(resp_valid), 32'd0);
        step(); #1;
        check("mul_rv_t2", 32'(resp_valid), 32'd0);
        step(); #1;
        check("mul_rv_t3", 32'(resp_valid), 32'd1);
        check("mul_data", resp_data, 32'h40C00000);
        check("mul_id", 32'(resp_id), 32'd0);
        step(); #1;
        check("mul_idle", 32'(busy), 32'd0);

        // Single add from requester 1, busy for LATENCY+1 cycles
        step();
        req1_valid = 1'b1; req1_op = 1'b0; req1_a = 32'h3F800000; req1_b = 32'h3F800000;
        #1;
        check("add_rdy1", 32'(req1_ready), 32'd1);
        nb = 0; cap_data = 32'h0; cap_id = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            req1_valid = 1'b0;
            #1;
            if (busy) nb++;
            if (resp_valid) begin
                cap_data = resp_data;
                cap_id   = resp_id;
            end
        end
        check("add_busy_cycles", 32'(nb), 32'd3);
        check("add_data", cap_data, 32'h40000000);
        check("add_id", 32'(cap_id), 32'd1);

        // Backpressure: DONE held while resp_ready is low
        resp_ready = 1'b0;
        step();
        req1_valid = 1'b1; req1_op = 1'b1; req1_a = 32'h3F800000; req1_b = 32'h40400000;
        #1;
        check("bp_rdy1", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0;
        step();
        step();
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'h40000000; req0_b = 32'h40400000;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_rv", 32'(resp_valid), 32'd1);
            check("bp_data", resp_data, 32'h40400000);
            check("bp_id", 32'(resp_id), 32'd1);
            check("bp_rdy0", 32'(req0_ready), 32'd0);
            check("bp_rdy1", 32'(req1_ready), 32'd0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        check("bp_rdy0_same", 32'(req0_ready), 32'd0);
        step(); #1;
        check("bp_rdy0_resume", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        step(); #1;
        check("bp_next_rv", 32'(resp_valid), 32'd1);
        check("bp_next_data", resp_data, 32'h40A00000);
        check("bp_next_id", 32'(resp_id), 32'd0);
        step();

        // Reset during EXEC drops the operation
        step();
        req0_valid = 1'b1; req0_op = 1'b1; req0_a = 32'h7F800000; req0_b = 32'h00000000;
        #1;
        check("rx_rdy0", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0; reset = 1'b1;
        #1;
        check("rx_busy", 32'(busy), 32'd1);
        step();
        reset = 1'b0;
        #1;
        check("rx_busy_after", 32'(busy), 32'd0);
        check("rx_rv", 32'(resp_valid), 32'd0);
        check("rx_fua", fu_a, 32'd0);
        check("rx_fuop", 32'(fu_op), 32'd0);
        check("rx_rdata", resp_data, 32'd0);
        check("rx_rid", 32'(resp_id), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            check("rx_no_resp", 32'(resp_valid), 32'd0);
        end
        step();
        req0_valid = 1'b1;
        #1;
        check("rx_new_rdy0", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        step(); #1;
        check("rx_new_rv", 32'(resp_valid), 32'd1);
        check("rx_new_data", resp_data, 32'h7FC00000);
        step();

        // Contention: both requesters valid continuously
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 32'h40000000; req0_b = 32'h40400000;
        req1_valid = 1'b1; req1_op = 1'b1; req1_a = 32'h40000000; req1_b = 32'h40400000;
        for (int k = 0; k < 4; k++) begin
            n = 0; got = 1'b0; winner = 1'b0;
            while (!got && n < 20) begin
                #1;
                check("ct_both_rdy", 32'(req0_ready && req1_ready), 32'd0);
                if (req0_ready || req1_ready) begin
                    winner = req1_ready;
                    got = 1'b1;
                end
                step();
                n++;
            end
            if (!got) check("ct_grant_timeout", 32'd0, 32'd1);
`ifdef FP_ARB_ROUND_ROBIN_EN
            exp_w = (k % 2) == 1;
`else
            exp_w = 1'b0;
`endif
            check("ct_winner", 32'(winner), 32'(exp_w));
            n = 0; got = 1'b0;
            while (!got && n < 20) begin
                #1;
                if (resp_valid) got = 1'b1;
                else step();
                n++;
            end
            if (!got) check("ct_resp_timeout", 32'd0, 32'd1);
            check("ct_resp_id", 32'(resp_id), 32'(exp_w));
            check("ct_resp_data", resp_data, exp_w ? 32'h40C00000 : 32'h40A00000);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_unit_arbiter.md
# fp_unit_arbiter

Sequencer and two-port arbiter for the shared single-precision floating-point datapath: the combinational adder and the combinational multiplier, muxed by an op select. It accepts operations from two requesters (requester 0 is the multicycle core's FP execute step, requester 1 is the secondary client), registers the operands, and holds them stable on the unit for a fixed settle window. It then captures the result and returns it with a requester ID under a valid/ready handshake. Only one operation is in flight at any time.

## Interface

Parameters:
- LATENCY, default 2: number of EXEC cycles the combinational unit is given to settle; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  1  0 = add, 1 = multiply.
- req0_a, req0_b  in  32  IEEE-754 single-precision operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  1  requester that issued the result.
- resp_data  out  32  captured result.
- fu_op  out  1  op select to the FP unit.
- fu_a, fu_b  out  32  registered operands to the FP unit.
- fu_result  in  32  FP unit output, combinational from fu_op/fu_a/fu_b.
- busy  out  1  high in EXEC or DONE.

## Operation

States: IDLE, EXEC, DONE.

IDLE:
- reqN_ready is combinational and is high only for the arbitration winner among valid requesters.
- A handshake is reqN_valid && reqN_ready. On a handshake, latch op/a/b into fu_op/fu_a/fu_b, set the ID register to N, load cnt = LATENCY-1, and go to EXEC.
- If no requester is valid, stay in IDLE.

EXEC:
- fu_* outputs are held constant.
- If cnt != 0, decrement cnt.
- If cnt == 0, capture fu_result into resp_data, drive resp_id from the ID register, and go to DONE.

DONE:
- resp_valid is high; resp_data and resp_id are stable.
- When resp_ready is high, go to IDLE. The next request can be accepted in the following cycle, not in the same cycle.

General rules:
- reqN_ready is low in EXEC and DONE and during the reset cycle.
- The block does no arithmetic on the data. All FP arithmetic is in the unit. The block passes fu_result through without modification, with no interpretation of NaN or Inf.
- Arbitration uses a last_grant register, updated on every handshake.
  - Both requesters valid: grant goes to !last_grant.
  - One requester valid: that one is granted.
  - Reset value last_grant = 1, so requester 0 wins the first tie.
- A requester must hold valid and operands stable until ready. The block does not latch a request that is withdrawn before its handshake.

## Timing

Latency and throughput:
- Handshake at cycle t.
- fu_* are valid from t+1.
- EXEC occupies t+1 .. t+LATENCY.
- resp_valid rises at t+LATENCY+1.
- Peak throughput is one operation per LATENCY+2 cycles, assuming resp_ready is held high.

Reset values (synchronous, effective at the next clock edge):
- State is IDLE; cnt = 0; last_grant = 1.
- fu_op = 0, fu_a = 0, fu_b = 0.
- resp_valid = 0, resp_id = 0, resp_data = 0.
- busy = 0; req0_ready = req1_ready = 0.

Boundary cases:
- Reset during EXEC or DONE: the operation is dropped with no response, and the next cycle is IDLE.
- resp_ready held low: DONE is held indefinitely, and both reqN_ready stay low.
- LATENCY = 1: EXEC lasts exactly one cycle.
- Both requesters valid on the cycle DONE exits: the grant is decided in the following IDLE cycle by last_grant.

## Configuration

Macro FP_ARB_ROUND_ROBIN_EN:
- Defined: round-robin arbitration via last_grant, as described above.
- Undefined: fixed priority, where requester 0 always wins when both are valid. The last_grant register is not implemented. All other behaviour and timing are identical.

## Test plan

- Single multiply, LATENCY=2: req0 mul, a=0x40000000 (2.0), b=0x40400000 (3.0) -> resp_valid at t+3, resp_data=0x40C00000, resp_id=0.
- Single add: req1 add, a=0x3F800000, b=0x3F800000 -> resp_data=0x40000000, resp_id=1, busy high for 3 cycles.
- Contention with round robin: both valid continuously -> grants alternate 0,1,0,1 across four operations, with no cycle where both ready are high.
- Backpressure: resp_ready low for 5 cycles in DONE -> resp_data and resp_id stable, both ready low, and acceptance resumes the cycle after resp_ready rises.
- Reset in EXEC: assert reset at t+1 -> no resp_valid, all outputs at reset values, and a new request is accepted afterwards with correct results.
- Macro undefined: both valid continuously -> requester 0 granted every time and requester 1 starved.
